// File: rtl/line_raster.sv
// Bresenham line rasteriser: any-octant line between two endpoints, gated by a
// repeating 16-bit dash mask, emitted on a registered single-slot valid/ready stream.
module line_raster #(
  parameter int CW = 10,
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] x0,
  input  logic [CW-1:0] y0,
  input  logic [CW-1:0] x1,
  input  logic [CW-1:0] y1,
  input  logic [PW-1:0] color,
  input  logic [15:0]   pattern,
  output logic          busy,
  output logic          done,
  output logic          px_valid,
  input  logic          px_ready,
  output logic [CW-1:0] px_x,
  output logic [CW-1:0] px_y,
  output logic [PW-1:0] px_data
);

  typedef enum logic [1:0] {IDLE, SETUP, RUN, DRAIN} state_t;

  state_t state, state_next;

  logic [CW-1:0]        x0_r, y0_r, x1_r, y1_r;
  logic [PW-1:0]        color_r;
  logic [15:0]          pattern_r;
  logic [3:0]           idx;
  logic [CW-1:0]        dx, dy, x, y;
  logic                 sx_neg, sy_neg;
  logic signed [CW+1:0] err;

  logic                 slot_free, step, final_step;
  logic [CW-1:0]        dx_c, dy_c;
  logic signed [CW+1:0] err_init, err_next;
  logic signed [CW+2:0] e2;
  logic                 x_move, y_move;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SETUP;
      SETUP:   state_next = RUN;
      RUN:     if (final_step) state_next = DRAIN;
      DRAIN:   if (slot_free) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs and step qualification
  always_comb begin
    busy       = (state != IDLE);
    slot_free  = !px_valid || px_ready;
    step       = (state == RUN) && slot_free;
    final_step = step && (x == x1_r) && (y == y1_r);
  end

  // Setup deltas and the per-step error update; both tests use the pre-step err
  always_comb begin
    dx_c     = (x1_r >= x0_r) ? (x1_r - x0_r) : (x0_r - x1_r);
    dy_c     = (y1_r >= y0_r) ? (y1_r - y0_r) : (y0_r - y1_r);
    err_init = $signed({2'b00, dx_c}) - $signed({2'b00, dy_c});
    e2       = {err, 1'b0};
    x_move   = e2 >= -$signed({3'b000, dy});
    y_move   = e2 <= $signed({3'b000, dx});
    err_next = err;
    if (x_move) err_next = err_next - $signed({2'b00, dy});
    if (y_move) err_next = err_next + $signed({2'b00, dx});
  end

  // Datapath, output slot and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_r      <= '0;
      y0_r      <= '0;
      x1_r      <= '0;
      y1_r      <= '0;
      color_r   <= '0;
      pattern_r <= '0;
      idx       <= '0;
      dx        <= '0;
      dy        <= '0;
      sx_neg    <= 1'b0;
      sy_neg    <= 1'b0;
      err       <= '0;
      x         <= '0;
      y         <= '0;
      done      <= 1'b0;
      px_valid  <= 1'b0;
      px_x      <= '0;
      px_y      <= '0;
      px_data   <= '0;
    end else begin
      done <= (state == DRAIN) && slot_free;
      if (state == IDLE && start) begin
        x0_r      <= x0;
        y0_r      <= y0;
        x1_r      <= x1;
        y1_r      <= y1;
        color_r   <= color;
        pattern_r <= pattern;
        idx       <= '0;
      end
      if (state == SETUP) begin
        dx     <= dx_c;
        dy     <= dy_c;
        sx_neg <= (x1_r < x0_r);
        sy_neg <= (y1_r < y0_r);
        err    <= err_init;
        x      <= x0_r;
        y      <= y0_r;
      end
      if (px_valid && px_ready) px_valid <= 1'b0;
      if (step) begin
        if (pattern_r[idx]) begin
          px_x     <= x;
          px_y     <= y;
          px_data  <= color_r;
          px_valid <= 1'b1;
        end
        idx <= idx + 4'd1;
        if (!final_step) begin
          err <= err_next;
          if (x_move) x <= sx_neg ? x - 1'b1 : x + 1'b1;
          if (y_move) y <= sy_neg ? y - 1'b1 : y + 1'b1;
        end
      end
    end
  end

endmodule
